mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 154 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// Combined memory-access / writeback pipeline stage with a two-state
// handshake FSM (IDLE, WAIT).
//
// Behaviour:
//   - ALU ops retire one cycle after they are accepted.
//   - Loads and stores raise mem_req and wait for mem_ack.
//     If both ex_mem_read and ex_mem_write are set, the op is a load.
//   - A bounded wait counter aborts a stuck transaction. The abort sets
//     bus_err, which stays set until reset.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   ex_*             upstream instruction (valid/ready handshake)
//   flush            squash the current or incoming instruction
//   mem_*            memory request interface (req/ack)
//   wb_*             writeback mux inputs, select, register-file strobe
//   wb_valid         one-cycle retire pulse
//   bus_err          sticky timeout flag
module mem_wb_stage #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [DATA_W-1:0]  ex_alu,
    input  logic [DATA_W-1:0]  ex_sdata,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_reg_write,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               flush,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [DATA_W-1:0]  wb_alu,
    output logic [DATA_W-1:0]  wb_load,
    output logic               wb_sel,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               wb_we,
    output logic               wb_valid,
    output logic               bus_err
);

    // The counter only has to reach TIMEOUT-1. The abort fires at the end
    // of the TIMEOUT-th WAIT cycle, so an ack in that same cycle still wins.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 drop;
    logic                 is_load;
    logic                 rw_lat;
    logic [RADDR_W-1:0]   rd_lat;
    logic                 accept;
    logic                 is_mem;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready & ~flush;
    assign is_mem   = ex_mem_read | ex_mem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            drop      <= 1'b0;
            is_load   <= 1'b0;
            rw_lat    <= 1'b0;
            rd_lat    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_alu    <= '0;
            wb_load   <= '0;
            wb_sel    <= 1'b0;
            wb_rd     <= '0;
            wb_we     <= 1'b0;
            wb_valid  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            // Retire strobes are pulses. Data outputs hold between pulses.
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            wb_alu   <= ex_alu;
                            wb_rd    <= ex_rd;
                            wb_sel   <= 1'b0;
                            wb_we    <= ex_reg_write;
                            wb_valid <= 1'b1;
                        end else begin
                            mem_addr  <= ex_alu;
                            mem_wdata <= ex_sdata;
                            // A read+write op is a load, so it must not write memory.
                            mem_we    <= ex_mem_write & ~ex_mem_read;
                            mem_req   <= 1'b1;
                            is_load   <= ex_mem_read;
                            rw_lat    <= ex_reg_write;
                            rd_lat    <= ex_rd;
                            cnt       <= '0;
                            drop      <= 1'b0;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        drop    <= 1'b0;
                        state   <= IDLE;
                        // A flush in the ack cycle itself also squashes the retire.
                        if (!(drop | flush)) begin
                            wb_valid <= 1'b1;
                            if (is_load) begin
                                wb_load <= mem_rdata;
                                wb_alu  <= mem_addr;
                                wb_sel  <= 1'b1;
                                wb_rd   <= rd_lat;
                                wb_we   <= rw_lat;
                            end
                        end
                    end else if (cnt == LAST) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        drop    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Directed testbench for mem_wb_stage. The DUT uses TIMEOUT = 8, so the
// abort path can be exercised in a few cycles. Inputs change 1 ns after a
// rising edge, and outputs are sampled at that same point.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_alu;
    logic [15:0] ex_sdata;
    logic [2:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] wb_alu;
    logic [15:0] wb_load;
    logic        wb_sel;
    logic [2:0]  wb_rd;
    logic        wb_we;
    logic        wb_valid;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;

    mem_wb_stage #(
        .DATA_W (16),
        .RADDR_W(3),
        .TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_alu      (ex_alu),
        .ex_sdata    (ex_sdata),
        .ex_rd       (ex_rd),
        .ex_reg_write(ex_reg_write),
        .ex_mem_read (ex_mem_read),
        .ex_mem_write(ex_mem_write),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_alu      (wb_alu),
        .wb_load     (wb_load),
        .wb_sel      (wb_sel),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .wb_valid    (wb_valid),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one upstream instruction slot.
    task automatic applyStimulus(input logic v, input logic [15:0] alu, input logic [15:0] sdata,
                                 input logic [2:0] rd, input logic rw, input logic mr, input logic mw);
        ex_valid     = v;
        ex_alu       = alu;
        ex_sdata     = sdata;
        ex_rd        = rd;
        ex_reg_write = rw;
        ex_mem_read  = mr;
        ex_mem_write = mw;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        idle();
        #1;
        // Reset state
        checkOutput("rst_ex_ready", ex_ready, 1);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_wb_alu", wb_alu, 0);
        checkOutput("rst_bus_err", bus_err, 0);
        step();
        rst_n = 1'b1;
        step();

        // ALU op
        applyStimulus(1'b1, 16'h0006, 16'h0, 3'd3, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        checkOutput("alu_valid", wb_valid, 1);
        checkOutput("alu_we", wb_we, 1);
        checkOutput("alu_sel", wb_sel, 0);
        checkOutput("alu_data", wb_alu, 16'h0006);
        checkOutput("alu_rd", wb_rd, 3);
        checkOutput("alu_ready", ex_ready, 1);
        step();
        checkOutput("alu_valid_pulse", wb_valid, 0);
        checkOutput("alu_we_pulse", wb_we, 0);
        checkOutput("alu_hold", wb_alu, 16'h0006);

        // Load, acked after 3 further wait cycles
        applyStimulus(1'b1, 16'h0010, 16'h0, 3'd5, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("ld_req", mem_req, 1);
            checkOutput("ld_addr", mem_addr, 16'h0010);
            checkOutput("ld_we", mem_we, 0);
            checkOutput("ld_ready", ex_ready, 0);
            checkOutput("ld_novalid", wb_valid, 0);
            step();
        end
        // The ALU op offered in the ack cycle must wait until IDLE.
        applyStimulus(1'b1, 16'h0077, 16'h0, 3'd2, 1'b1, 1'b0, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hAAAA;
        checkOutput("ld_req_ack", mem_req, 1);
        step();
        mem_ack = 1'b0;
        checkOutput("ld_valid", wb_valid, 1);
        checkOutput("ld_sel", wb_sel, 1);
        checkOutput("ld_load", wb_load, 16'hAAAA);
        checkOutput("ld_wbwe", wb_we, 1);
        checkOutput("ld_wbalu", wb_alu, 16'h0010);
        checkOutput("ld_rd", wb_rd, 5);
        checkOutput("ld_req_off", mem_req, 0);
        checkOutput("ld_ready_back", ex_ready, 1);
        step();
        idle();
        checkOutput("post_ack_alu_valid", wb_valid, 1);
        checkOutput("post_ack_alu_data", wb_alu, 16'h0077);
        checkOutput("post_ack_sel", wb_sel, 0);
        checkOutput("post_ack_load_hold", wb_load, 16'hAAAA);

        // Store with immediate ack
        applyStimulus(1'b1, 16'h0020, 16'h1234, 3'd1, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        checkOutput("st_req", mem_req, 1);
        checkOutput("st_we", mem_we, 1);
        checkOutput("st_wdata", mem_wdata, 16'h1234);
        checkOutput("st_addr", mem_addr, 16'h0020);
        checkOutput("st_novalid", wb_valid, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checkOutput("st_valid", wb_valid, 1);
        checkOutput("st_wbwe", wb_we, 0);
        checkOutput("st_req_off", mem_req, 0);
        step();
        checkOutput("st_valid_pulse", wb_valid, 0);

        // Read and write both set: treated as a load
        applyStimulus(1'b1, 16'h0030, 16'hFFFF, 3'd4, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        checkOutput("rw_memwe", mem_we, 0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
        step();
        mem_ack = 1'b0;
        checkOutput("rw_sel", wb_sel, 1);
        checkOutput("rw_load", wb_load, 16'h5555);
        checkOutput("rw_wbwe", wb_we, 1);
        step();

        // Flush in IDLE blocks accept
        applyStimulus(1'b1, 16'h0099, 16'h0, 3'd6, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        checkOutput("fli_valid", wb_valid, 0);
        checkOutput("fli_alu_hold", wb_alu, 16'h0030);
        checkOutput("fli_req", mem_req, 0);

        // Flush in WAIT drops the retire but the memory side completes
        applyStimulus(1'b1, 16'h0040, 16'h0, 3'd7, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        checkOutput("flw_req", mem_req, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("flw_req_held", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        checkOutput("flw_req_off", mem_req, 0);
        checkOutput("flw_novalid", wb_valid, 0);
        checkOutput("flw_nowe", wb_we, 0);
        checkOutput("flw_load_hold", wb_load, 16'h5555);
        checkOutput("flw_ready", ex_ready, 1);
        applyStimulus(1'b1, 16'h0021, 16'h0, 3'd2, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        checkOutput("flw_next_valid", wb_valid, 1);
        checkOutput("flw_next_alu", wb_alu, 16'h0021);

        // Ack in IDLE is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checkOutput("idle_ack_valid", wb_valid, 0);
        checkOutput("idle_ack_req", mem_req, 0);

        // Ack in the 8th WAIT cycle beats the timeout
        applyStimulus(1'b1, 16'h0050, 16'h0, 3'd1, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        for (int i = 0; i < 7; i++) begin
            checkOutput("to8_req", mem_req, 1);
            step();
        end
        checkOutput("to8_req_last", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0;
        checkOutput("to8_valid", wb_valid, 1);
        checkOutput("to8_load", wb_load, 16'h1111);
        checkOutput("to8_err", bus_err, 0);
        step();

        // No ack: abort after 8 WAIT cycles
        applyStimulus(1'b1, 16'h0060, 16'h0, 3'd1, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        for (int i = 0; i < 8; i++) begin
            checkOutput("to_req", mem_req, 1);
            checkOutput("to_err_pre", bus_err, 0);
            step();
        end
        checkOutput("to_req_off", mem_req, 0);
        checkOutput("to_err", bus_err, 1);
        checkOutput("to_novalid", wb_valid, 0);
        checkOutput("to_ready", ex_ready, 1);
        step();
        step();
        checkOutput("to_err_sticky", bus_err, 1);

        // Reset during WAIT clears everything without a clock edge
        applyStimulus(1'b1, 16'h0070, 16'h0, 3'd3, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        checkOutput("rw_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_req", mem_req, 0);
        checkOutput("mrst_ready", ex_ready, 1);
        checkOutput("mrst_err", bus_err, 0);
        checkOutput("mrst_addr", mem_addr, 0);
        checkOutput("mrst_wbalu", wb_alu, 0);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h000C, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        checkOutput("mrst_alu_valid", wb_valid, 1);
        checkOutput("mrst_alu_data", wb_alu, 16'h000C);
        checkOutput("mrst_alu_rd", wb_rd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
